vga_line_feeder: RTL and testbench
==================================

// Module: vga_line_feeder
// PURPOSE
//  Producer side of the VGA line-buffer write interface. Fetches 12-bit RGB444 pixels from a
//  framebuffer memory (row-major, BUF_W x BUF_H, one pixel per word) and stages them in a
//  show-ahead FIFO. Streams one pixel per clk into the display's w_data port while wr_ready is
//  high. Lines go out in order, and the frame wraps. Sits between the memory arbiter and the VGA unit.
// PARAMETERS
//  BUF_W      128  pixels per line; power of two
//  BUF_H      96   lines per frame
//  ADDR_W     16   memory word-address width
//  FIFO_DEPTH 128  staging FIFO entries; power of two, >= BUF_W
// PORTS
//  clk          in   1       system clock (same clk as the VGA write side)
//  rst          in   1       asynchronous, active-high reset
//  enable       in   1       run; low = idle, flush and output black
//  fb_base      in   ADDR_W  framebuffer base word address; sampled at each frame start
//  mem_req      out  1       read request
//  mem_addr     out  ADDR_W  read word address, valid with mem_req
//  mem_gnt      in   1       request accepted this cycle
//  mem_rvalid   in   1       read data valid; in order, latency >= 1 cycle after gnt
//  mem_rdata    in   12      read pixel {r,g,b}
//  wr_ready     in   1       VGA consumes w_data on every clk where this is high
//  w_data       out  12      pixel presented to VGA (FIFO head)
//  underrun     out  1       sticky: wr_ready was high while FIFO was empty
//  frame_done   out  1       1-cycle pulse when the last pixel of a frame is popped
// BEHAVIOUR
//  Reset: mem_req=0, mem_addr=0, w_data=0, underrun=0, frame_done=0. FIFO is empty.
//   Fetch x/y=0 and pop x/y=0. Outstanding=0. FSM=IDLE.
//  FSM (fetch side):
//   - IDLE: go to FRAME_START when enable=1.
//   - FRAME_START (1 cycle): latch base=fb_base; go to FETCH.
//   - FETCH: assert mem_req while (count + outstanding) < FIFO_DEPTH.
//     mem_addr = base + fy*BUF_W + fx, computed modulo 2^ADDR_W.
//     - On gnt: fx++; outstanding++.
//     - When fx wraps from BUF_W-1 to 0: fy++.
//     - When fy wraps from BUF_H-1 to 0: go to FRAME_START. The next frame's prefetch proceeds
//       without a gap.
//  mem_req and mem_addr hold steady until gnt; mem_req never drops mid-request.
//  rvalid writes mem_rdata into the FIFO and decrements outstanding.
//   - A simultaneous gnt and rvalid leaves outstanding unchanged.
//   - Overflow is impossible by the credit rule; an assertion checks it.
//  Pop side:
//   - w_data = FIFO head, combinational, when count>0; else 12'h000.
//   - Pop every cycle wr_ready=1 and count>0.
//   - wr_ready=1 with count=0: no pop, underrun<=1. Pop counters do not advance; the VGA slot
//     gets black.
//   - Push and pop in the same cycle, including at count=FIFO_DEPTH-... boundaries: count is
//     unchanged.
//  Pop counters px/py track the displayed position. frame_done pulses on the pop of
//   (BUF_W-1, BUF_H-1).
//  enable falling while running:
//   - Drop mem_req at once only if no gnt occurs in that cycle.
//   - Wait for outstanding to reach 0, discarding rvalid data.
//   - Flush the FIFO and reset all counters; return to IDLE.
//   - w_data is forced to 0 while enable=0. underrun is not set while enable=0.
//  Re-enable restarts at pixel (0,0) with a freshly sampled fb_base.
//  Asynchronous rst mid-frame returns everything to its reset state immediately. Late rvalid
//   after reset is ignored until the first new gnt.
//  Widths: fx is log2(BUF_W) bits, fy is clog2(BUF_H) bits; count and outstanding are
//   clog2(FIFO_DEPTH)+1 bits.
// STRUCTURE
//  Package vga_pkg holds:
//   - pixel_t (logic [11:0]);
//   - constants VGA_BUF_W=128, VGA_BUF_H=96;
//   - typedef enum {IDLE, FRAME_START, FETCH, DRAIN} feed_state_t.
//  One sub-module: sync_fifo (show-ahead, single clk, async rst, with a flush input). The rest
//   of the logic stays in this module.
// TESTING
//  1 Memory model with gnt=1 and 2-cycle latency; fb[i]=i[11:0]; fb_base=0x1000.
//    Hold wr_ready low 200 cycles, then high 128 cycles.
//    -> 128 requests at 0x1000..0x107F. w_data = 0x000..0x07F on consecutive cycles.
//    underrun=0.
//  2 Run a full frame (96 bursts of 128, gaps of 50 cycles).
//    -> frame_done pulses once on the pop of pixel 12287, whose w_data=0xFFF.
//    The next request address is 0x1000, with fb_base re-sampled.
//  3 Random mem_gnt (~50%) and rvalid latency of 1..4 cycles, wr_ready low for 40 cycles.
//    -> count+outstanding never exceeds 128; mem_addr is stable while mem_req and !gnt.
//  4 wr_ready high from cycle 0 after reset -> w_data=0 and underrun=1 (sticky) until the next rst.
//  5 Drop enable mid-line with 3 reads outstanding -> the 3 rvalids are discarded and w_data=0.
//    Re-enable with fb_base=0x2000 -> the first mem_addr is 0x2000.
//  6 Assert rst mid-burst -> all outputs are 0 in the same cycle; the FSM is in IDLE.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and frame geometry for the VGA line feeder.
package vga_pkg;

  typedef logic [11:0] pixel_t;

  localparam int VGA_BUF_W = 128;
  localparam int VGA_BUF_H = 96;

  typedef enum logic [1:0] {IDLE, FRAME_START, FETCH, DRAIN} feed_state_t;

endpackage

// File: rtl/vga_line_feeder_sync_fifo.sv
// Show-ahead single-clock FIFO: rdata is the head entry whenever count is non-zero.
module sync_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  pixel_t                 wdata,
  input  logic                   pop,
  output pixel_t                 rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  pixel_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

  // The credit scheme upstream must never let a push land on a full FIFO.
  assert property (@(posedge clk) disable iff (rst) !(push && !pop && count == FULL));
  assert property (@(posedge clk) disable iff (rst) !(pop && count == '0));

endmodule

// File: rtl/vga_line_feeder.sv
// Fetches framebuffer pixels into a staging FIFO and streams them to the VGA write port.
module vga_line_feeder
  import vga_pkg::*;
#(
  parameter int BUF_W      = VGA_BUF_W,
  parameter int BUF_H      = VGA_BUF_H,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [ADDR_W-1:0] fb_base,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  pixel_t            mem_rdata,
  input  logic              wr_ready,
  output pixel_t            w_data,
  output logic              underrun,
  output logic              frame_done
);

  localparam int FX_W  = $clog2(BUF_W);
  localparam int FY_W  = $clog2(BUF_H);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FX_W-1:0]  X_MAX = FX_W'(BUF_W - 1);
  localparam logic [FY_W-1:0]  Y_MAX = FY_W'(BUF_H - 1);
  localparam logic [CNT_W:0]   CREDIT_LIM = (CNT_W + 1)'(FIFO_DEPTH);

  feed_state_t       state, state_nxt;
  logic [FX_W-1:0]   fx, px;
  logic [FY_W-1:0]   fy, py;
  logic [CNT_W-1:0]  count, outstanding;
  logic [ADDR_W-1:0] base, fetch_addr;
  logic              credit_ok, gnt_fire, rsp_fire, push, pop, running, drain_done;
  pixel_t            head;

  // Reads in flight count against FIFO space so a returning pixel always has a slot.
  assign credit_ok  = ({1'b0, count} + {1'b0, outstanding}) < CREDIT_LIM;
  assign fetch_addr = base + ADDR_W'({fy, fx});
  assign gnt_fire   = mem_req && mem_gnt;
  assign rsp_fire   = mem_rvalid && (outstanding != '0);
  assign push       = rsp_fire && (state != DRAIN);
  assign running    = enable && (state != DRAIN);
  assign pop        = running && wr_ready && (count != '0);
  assign drain_done = (state == DRAIN) && (outstanding == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (enable) state_nxt = FRAME_START;
      FRAME_START: state_nxt = enable ? FETCH : DRAIN;
      FETCH: begin
        if (!enable)                                       state_nxt = DRAIN;
        else if (gnt_fire && fx == X_MAX && fy == Y_MAX)   state_nxt = FRAME_START;
      end
      DRAIN:       if (outstanding == '0) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req  = (state == FETCH) && credit_ok;
    mem_addr = mem_req ? fetch_addr : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base        <= '0;
      fx          <= '0;
      fy          <= '0;
      outstanding <= '0;
    end else begin
      if (state == FRAME_START) base <= fb_base;
      outstanding <= outstanding + CNT_W'(gnt_fire) - CNT_W'(rsp_fire);
      if (drain_done) begin
        fx <= '0;
        fy <= '0;
      end else if (gnt_fire) begin
        fx <= (fx == X_MAX) ? '0 : fx + 1'b1;
        if (fx == X_MAX) fy <= (fy == Y_MAX) ? '0 : fy + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px       <= '0;
      py       <= '0;
      underrun <= 1'b0;
    end else begin
      if (enable && wr_ready && count == '0) underrun <= 1'b1;
      if (drain_done) begin
        px <= '0;
        py <= '0;
      end else if (pop) begin
        px <= (px == X_MAX) ? '0 : px + 1'b1;
        if (px == X_MAX) py <= (py == Y_MAX) ? '0 : py + 1'b1;
      end
    end
  end

  sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (drain_done),
    .push  (push),
    .wdata (mem_rdata),
    .pop   (pop),
    .rdata (head),
    .count (count)
  );

  assign w_data     = (running && count != '0) ? head : '0;
  assign frame_done = pop && (px == X_MAX) && (py == Y_MAX);

endmodule

// File: tb/tb_vga_line_feeder.sv
// Scoreboard bench for vga_line_feeder: memory model, address checker and pop monitor.
module tb_vga_line_feeder;
  import vga_pkg::*;

  localparam int FRAME_PIX = 128 * 96;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] fb_base = 16'h1000;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  pixel_t      mem_rdata = '0;
  logic        wr_ready = 1'b0;
  pixel_t      w_data;
  logic        underrun;
  logic        frame_done;

  vga_line_feeder #(.BUF_W(128), .BUF_H(96), .ADDR_W(16), .FIFO_DEPTH(128)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fb_base(fb_base),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wr_ready(wr_ready), .w_data(w_data), .underrun(underrun), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] addr; int due; int epoch; } grant_t;
  typedef struct { pixel_t data; logic fd; } exp_t;

  grant_t gq[$];
  exp_t   eq[$];
  grant_t g_head;
  exp_t   e_head;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, epoch = 0, lat = 2, fcnt = 0, ngrant = 0, fd_cnt = 0;
  int aidx = 0, pidx = 0;
  bit gnt_rand = 0, gnt_off = 0, chk_stab = 0, prev_pend = 0;
  logic [15:0] abase = 16'h1000, pbase = 16'h1000, prev_addr = '0;
  logic [15:0] first_addr = '0, wrap_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory side: grant and return data one step after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    mem_gnt    = gnt_off ? 1'b0 : (gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    mem_rvalid = 1'b0;
    if (gq.size() > 0 && gq[0].due <= cyc) begin
      g_head     = gq.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata  = g_head.addr[11:0];
      if (g_head.epoch == epoch) fcnt++;
    end
  end

  // Request monitor: address order, hold-until-grant, credit bound.
  always @(negedge clk) begin
    if (chk_stab && prev_pend) begin
      check("req_held", 32'(mem_req), 32'd1);
      check("addr_held", 32'(mem_addr), 32'(prev_addr));
    end
    prev_pend = mem_req && !mem_gnt;
    prev_addr = mem_addr;
    if (chk_stab) check("credit_bound", 32'((fcnt + gq.size()) <= 128), 32'd1);
    if (mem_req && mem_gnt && !rst) begin
      check("mem_addr", 32'(mem_addr), 32'(abase + 16'(aidx)));
      if (ngrant == 0)         first_addr = mem_addr;
      if (ngrant == FRAME_PIX) wrap_addr  = mem_addr;
      ngrant++;
      aidx = (aidx + 1) % FRAME_PIX;
      gq.push_back('{mem_addr, cyc + (gnt_rand ? int'($urandom_range(1, 4)) : lat), epoch});
    end
  end

  // Pop monitor: every slot with wr_ready high consumes one expectation.
  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (wr_ready && !rst) begin
      if (eq.size() == 0) check("pop_expected", 32'(eq.size()), 32'd1);
      else begin
        e_head = eq.pop_front();
        check("w_data", 32'(w_data), 32'(e_head.data));
        check("frame_done", 32'(frame_done), 32'(e_head.fd));
      end
    end
  end

  task automatic pop_cycle(input bit black);
    exp_t e;
    @(posedge clk); #1;
    wr_ready = 1'b1;
    if (black) begin
      e.data = '0;
      e.fd   = 1'b0;
    end else begin
      e.data = 12'(pbase + 16'(pidx));
      e.fd   = (pidx == FRAME_PIX - 1);
      pidx   = (pidx + 1) % FRAME_PIX;
      fcnt--;
    end
    eq.push_back(e);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      wr_ready = 1'b0;
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_w_data", 32'(w_data), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));

    // Underrun straight out of reset, sticky until the next reset
    rst = 1'b0;
    enable = 1'b1;
    repeat (4) pop_cycle(1'b1);
    idle_cycles(1);
    check("underrun_set", 32'(underrun), 32'd1);
    idle_cycles(10);
    check("underrun_sticky", 32'(underrun), 32'd1);
    rst = 1'b1;
    enable = 1'b0;
    epoch++;
    fcnt = 0;
    #1;
    check("underrun_cleared", 32'(underrun), 32'd0);
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(30);
    aidx = 0; abase = 16'h1000; ngrant = 0; pidx = 0; pbase = 16'h1000;

    // First line: prefetch stops at FIFO depth, then streams 0x000..0x07F
    fb_base = 16'h1000;
    enable = 1'b1;
    idle_cycles(200);
    check("prefetch_count", 32'(ngrant), 32'd128);
    check("first_addr", 32'(first_addr), 32'h1000);
    repeat (128) pop_cycle(1'b0);
    idle_cycles(1);
    check("underrun_line0", 32'(underrun), 32'd0);

    // Rest of the frame; fetch wraps to the re-sampled base
    repeat (95) begin
      idle_cycles(50);
      repeat (128) pop_cycle(1'b0);
    end
    idle_cycles(50);
    check("frame_done_count", 32'(fd_cnt), 32'd1);
    check("wrap_addr", 32'(wrap_addr), 32'h1000);
    check("wrapped_fetch", 32'(ngrant > FRAME_PIX), 32'd1);
    check("underrun_frame", 32'(underrun), 32'd0);

    // Random grants and latencies with a consumer that waits for data
    gnt_rand = 1'b1;
    chk_stab = 1'b1;
    idle_cycles(40);
    repeat (300) begin
      if (fcnt >= 3) pop_cycle(1'b0);
      else           idle_cycles(1);
    end
    chk_stab = 1'b0;
    gnt_rand = 1'b0;
    idle_cycles(200);
    check("underrun_random", 32'(underrun), 32'd0);

    // Disable with three reads in flight, then restart at a new base
    lat = 6;
    repeat (3) pop_cycle(1'b0);
    for (int i = 0; i < 30; i++) begin
      if (gq.size() >= 3) break;
      idle_cycles(1);
    end
    check("inflight_reads", 32'(gq.size()), 32'd3);
    enable = 1'b0;
    gnt_off = 1'b1;
    epoch++;
    fcnt = 0;
    repeat (5) pop_cycle(1'b1);
    idle_cycles(20);
    check("drain_state", 32'(dut.state), 32'(IDLE));
    check("underrun_disabled", 32'(underrun), 32'd0);
    fb_base = 16'h2000;
    abase = 16'h2000; aidx = 0; ngrant = 0; pbase = 16'h2000; pidx = 0;
    gnt_off = 1'b0;
    lat = 2;
    enable = 1'b1;
    idle_cycles(200);
    check("restart_addr", 32'(first_addr), 32'h2000);
    repeat (20) pop_cycle(1'b0);

    // Asynchronous reset in the middle of a burst
    @(posedge clk); #2;
    rst = 1'b1;
    wr_ready = 1'b0;
    epoch++;
    fcnt = 0;
    #1;
    check("arst_mem_req", 32'(mem_req), 32'd0);
    check("arst_mem_addr", 32'(mem_addr), 32'd0);
    check("arst_w_data", 32'(w_data), 32'd0);
    check("arst_underrun", 32'(underrun), 32'd0);
    check("arst_frame_done", 32'(frame_done), 32'd0);
    check("arst_state", 32'(dut.state), 32'(IDLE));
    idle_cycles(3);
    rst = 1'b0;
    enable = 1'b0;
    idle_cycles(2);
    check("exp_queue_drained", 32'(eq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
